// File: rtl/hwpe_ctrl_ctx_sched.sv
// Context scheduler for a HWPE controller: hands out job contexts to
// offloading cores, queues committed jobs, sequences the engine and
// raises per-core done events.
// Optional build macro: HWPE_CTRL_SCHED_BROADCAST_EN (done event to all cores).
module hwpe_ctrl_ctx_sched #(
  parameter int unsigned N_CONTEXT = 2,
  parameter int unsigned N_CORES   = 16,
  localparam int unsigned CW = $clog2(N_CONTEXT),
  localparam int unsigned IW = $clog2(N_CORES)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clear_i,
  input  logic          acquire_req_i,
  input  logic [IW-1:0] acquire_id_i,
  output logic [CW-1:0] acquire_ctx_o,
  output logic          acquire_full_o,
  input  logic          trigger_i,
  output logic          start_o,
  input  logic          done_i,
  output logic [CW-1:0] running_ctx_o,
  output logic [CW:0]   nb_pending_o,
  output logic          busy_o,
  output logic [N_CORES-1:0] evt_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] run_q, run_d;
  logic [CW:0]   nb_q, nb_d;
  logic          rsv_q, rsv_d;
  logic [IW-1:0] owner_q [N_CONTEXT];
  logic [IW-1:0] owner_d [N_CONTEXT];

  logic acq_ok;
  logic commit;
  logic retire;

  assign acquire_full_o = rsv_q | (nb_q == (CW+1)'(N_CONTEXT));
  assign acquire_ctx_o  = ptr_q;
  assign running_ctx_o  = run_q;
  assign nb_pending_o   = nb_q;
  assign busy_o         = (state_q != IDLE);

  assign acq_ok = acquire_req_i & ~acquire_full_o;
  assign commit = trigger_i & rsv_q;
  assign retire = (state_q == DONE);

  // Context bookkeeping: reservation, owner capture, commit and queue depth.
  always_comb begin
    ptr_d   = ptr_q;
    rsv_d   = rsv_q;
    owner_d = owner_q;
    nb_d    = nb_q;
    if (acq_ok) begin
      rsv_d          = 1'b1;
      owner_d[ptr_q] = acquire_id_i;
    end
    if (commit) begin
      rsv_d = 1'b0;
      ptr_d = ptr_q + CW'(1);
    end
    unique case ({commit, retire})
      2'b10:   nb_d = nb_q + (CW+1)'(1);
      2'b01:   nb_d = nb_q - (CW+1)'(1);
      default: nb_d = nb_q;
    endcase
  end

  // Engine sequencing FSM: next state, start pulse and done events.
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    start_o = 1'b0;
    evt_o   = '0;
    unique case (state_q)
      IDLE: begin
        if (nb_q != '0)
          state_d = START;
      end
      START: begin
        start_o = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        if (done_i)
          state_d = DONE;
      end
      DONE: begin
`ifdef HWPE_CTRL_SCHED_BROADCAST_EN
        evt_o = '1;
`else
        evt_o[owner_q[run_q]] = 1'b1;
`endif
        run_d   = run_q + CW'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset and soft clear abort any job in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i | clear_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      run_q   <= '0;
      nb_q    <= '0;
      rsv_q   <= 1'b0;
      for (int i = 0; i < int'(N_CONTEXT); i++)
        owner_q[i] <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      run_q   <= run_d;
      nb_q    <= nb_d;
      rsv_q   <= rsv_d;
      owner_q <= owner_d;
    end
  end

endmodule

// File: tb/tb_hwpe_ctrl_ctx_sched.sv
// Directed self-checking bench for hwpe_ctrl_ctx_sched.
// Two instances: N_CONTEXT=2 (main) and N_CONTEXT=4 (overlap case).
module tb_hwpe_ctrl_ctx_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clr = 1'b0;
  logic        acq = 1'b0;
  logic [3:0]  id  = '0;
  logic        trg = 1'b0;
  logic        dn  = 1'b0;

  logic [0:0]  ctx2, run2;
  logic [1:0]  nb2;
  logic        full2, start2, busy2;
  logic [15:0] evt2;

  logic [1:0]  ctx4, run4;
  logic [2:0]  nb4;
  logic        full4, start4, busy4;
  logic [15:0] evt4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hwpe_ctrl_ctx_sched #(.N_CONTEXT(2), .N_CORES(16)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .clear_i(clr),
    .acquire_req_i(acq), .acquire_id_i(id),
    .acquire_ctx_o(ctx2), .acquire_full_o(full2),
    .trigger_i(trg), .start_o(start2), .done_i(dn),
    .running_ctx_o(run2), .nb_pending_o(nb2),
    .busy_o(busy2), .evt_o(evt2)
  );

  hwpe_ctrl_ctx_sched #(.N_CONTEXT(4), .N_CORES(16)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .clear_i(clr),
    .acquire_req_i(acq), .acquire_id_i(id),
    .acquire_ctx_o(ctx4), .acquire_full_o(full4),
    .trigger_i(trg), .start_o(start4), .done_i(dn),
    .running_ctx_o(run4), .nb_pending_o(nb4),
    .busy_o(busy4), .evt_o(evt4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ev(input int core);
`ifdef HWPE_CTRL_SCHED_BROADCAST_EN
    ev = 16'hFFFF;
`else
    ev = 16'(1) << core;
`endif
  endfunction

  int owners [4] = '{4, 9, 12, 15};

  initial begin
    // reset wins over a simultaneous acquire and trigger
    rst = 1'b1; acq = 1'b1; id = 4'd3; trg = 1'b1;
    tick();
    tick();
    rst = 1'b0; acq = 1'b0; trg = 1'b0;
    chk("rst_full", 32'(full2), 0);
    chk("rst_busy", 32'(busy2), 0);
    chk("rst_start", 32'(start2), 0);
    chk("rst_evt", 32'(evt2), 0);
    chk("rst_nb", 32'(nb2), 0);
    chk("rst_ctx", 32'(ctx2), 0);

    // single job from core 3
    acq = 1'b1; id = 4'd3;
    tick();
    acq = 1'b0;
    chk("j1_full", 32'(full2), 1);
    chk("j1_ctx", 32'(ctx2), 0);
    trg = 1'b1;
    tick();
    trg = 1'b0;
    chk("j1_start_c1", 32'(start2), 0);
    chk("j1_nb", 32'(nb2), 1);
    tick();
    chk("j1_start_c2", 32'(start2), 1);
    chk("j1_busy", 32'(busy2), 1);
    tick();
    chk("j1_start_off", 32'(start2), 0);
    dn = 1'b1;
    tick();
    dn = 1'b0;
    chk("j1_evt", 32'(evt2), 32'(ev(3)));
    chk("j1_run", 32'(run2), 0);
    tick();
    chk("j1_evt_off", 32'(evt2), 0);
    chk("j1_nb_end", 32'(nb2), 0);
    chk("j1_idle", 32'(busy2), 0);
    chk("j1_run_adv", 32'(run2), 1);

    // two jobs committed while engine is held in RUN
    acq = 1'b1; id = 4'd1;
    tick();
    acq = 1'b0; trg = 1'b1;
    tick();
    trg = 1'b0; acq = 1'b1; id = 4'd5;
    tick();
    acq = 1'b0; trg = 1'b1;
    tick();
    trg = 1'b0;
    chk("two_full", 32'(full2), 1);
    chk("two_nb", 32'(nb2), 2);
    chk("two_busy", 32'(busy2), 1);
    acq = 1'b1; id = 4'd7;
    tick();
    acq = 1'b0;
    chk("two_full_hold", 32'(full2), 1);
    chk("two_nb_hold", 32'(nb2), 2);
    chk("two_ctx_hold", 32'(ctx2), 1);
    dn = 1'b1;
    tick();
    dn = 1'b0;
    chk("two_evt_a", 32'(evt2), 32'(ev(1)));
    chk("two_run_a", 32'(run2), 1);
    tick();
    chk("two_nb_a", 32'(nb2), 1);
    tick();
    tick();
    dn = 1'b1;
    tick();
    dn = 1'b0;
    chk("two_evt_b", 32'(evt2), 32'(ev(5)));
    chk("two_run_b", 32'(run2), 0);
    tick();
    chk("two_nb_b", 32'(nb2), 0);

    // four back-to-back jobs, contexts alternate
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int j = 0; j < 4; j++) begin
      acq = 1'b1; id = 4'(owners[j]);
      tick();
      acq = 1'b0; trg = 1'b1;
      tick();
      trg = 1'b0;
      tick();
      chk($sformatf("b2b%0d_start", j), 32'(start2), 1);
      tick();
      dn = 1'b1;
      tick();
      dn = 1'b0;
      chk($sformatf("b2b%0d_evt", j), 32'(evt2), 32'(ev(owners[j])));
      chk($sformatf("b2b%0d_run", j), 32'(run2), 32'(j % 2));
      tick();
      chk($sformatf("b2b%0d_evt_off", j), 32'(evt2), 0);
    end

    // commit coinciding with DONE (4-context instance)
    rst = 1'b1;
    tick();
    rst = 1'b0;
    acq = 1'b1; id = 4'd2;
    tick();
    acq = 1'b0; trg = 1'b1;
    tick();
    trg = 1'b0; acq = 1'b1; id = 4'd6;
    tick();
    acq = 1'b0; trg = 1'b1;
    tick();
    trg = 1'b0; acq = 1'b1; id = 4'd8;
    tick();
    acq = 1'b0;
    chk("ovl_full4", 32'(full4), 1);
    chk("ovl_nb4", 32'(nb4), 2);
    chk("ovl_full2", 32'(full2), 1);
    dn = 1'b1;
    tick();
    dn = 1'b0;
    chk("ovl_evt4", 32'(evt4), 32'(ev(2)));
    chk("ovl_nb4_done", 32'(nb4), 2);
    trg = 1'b1;
    tick();
    trg = 1'b0;
    chk("ovl_nb4_same", 32'(nb4), 2);
    chk("ovl_ctx4", 32'(ctx4), 3);
    chk("ovl_nb2_notrg", 32'(nb2), 1);

    // soft clear during RUN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    acq = 1'b1; id = 4'd6;
    tick();
    acq = 1'b0; trg = 1'b1;
    tick();
    trg = 1'b0;
    tick();
    tick();
    chk("clr_busy_run", 32'(busy2), 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_busy", 32'(busy2), 0);
    chk("clr_nb", 32'(nb2), 0);
    chk("clr_evt", 32'(evt2), 0);
    chk("clr_full", 32'(full2), 0);
    dn = 1'b1;
    tick();
    dn = 1'b0;
    chk("clr_done_evt", 32'(evt2), 0);
    chk("clr_done_busy", 32'(busy2), 0);
    tick();
    chk("clr_done_evt2", 32'(evt2), 0);
    chk("clr_stay_idle", 32'(busy2), 0);

    // job from core 2 (all-ones event in broadcast build)
    acq = 1'b1; id = 4'd2;
    tick();
    acq = 1'b0; trg = 1'b1;
    tick();
    trg = 1'b0;
    tick();
    tick();
    dn = 1'b1;
    tick();
    dn = 1'b0;
    chk("bc_evt", 32'(evt2), 32'(ev(2)));
    tick();
    chk("bc_evt_off", 32'(evt2), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
